mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 opcode  input  6  instruction bits [31:26], sampled in DECODE.
REQ-005 zero  input  1  ALU zero flag, used in BRANCH only.
REQ-006 mem_ready  input  1  memory handshake; the access completes in a cycle where the request is high and mem_ready=1.
REQ-007 pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath enables and selects.
REQ-008 alu_src_b, alu_op, pc_src  output  2 each  datapath selects.
REQ-009 state  output  4  current state encoding.
REQ-010 instr_done  output  1  one-cycle pulse in the final cycle of each instruction.
REQ-011 illegal  output  1  high while in the trap state.
REQ-012 instr_count  output  32  count of retired instructions.

Function
REQ-013 States and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, BRANCH=8, AEX=9, AWB=10, JUMP=11, TRAP=12. Codes 13-15 SHALL go to FETCH on the next edge.
REQ-014 Outputs SHALL be decoded from the registered state, with mem_ready and zero gating only. Any output not listed for a state SHALL be 0.
REQ-015 FETCH outputs: mem_read=1, alu_src_b=01, ir_write=pc_write=mem_ready. Next state is DECODE if mem_ready=1, else FETCH.
REQ-016 DECODE outputs: alu_src_b=11. Next state by opcode: 000000->REX, 100011 or 101011->MEMADR, 000100->BRANCH, 001000->AEX, 000010->JUMP, any other->TRAP.
REQ-017 MEMADR outputs: alu_src_a=1, alu_src_b=10. Next state is MEMRD if the DECODE opcode was 100011, else MEMWR. The opcode SHALL be latched in DECODE.
REQ-018 MEMRD outputs: mem_read=1, i_or_d=1. It waits while mem_ready=0, then goes to MEMWB.
REQ-019 MEMWB outputs: reg_write=1, mem_to_reg=1, reg_dst=0. Next state is FETCH; instr_done=1.
REQ-020 MEMWR outputs: mem_write=1, i_or_d=1. It waits while mem_ready=0, then goes to FETCH; instr_done=mem_ready.
REQ-021 REX outputs: alu_src_a=1, alu_src_b=00, alu_op=10. Next state is RWB.
REQ-022 RWB outputs: reg_write=1, reg_dst=1. Next state is FETCH; instr_done=1.
REQ-023 BRANCH outputs: alu_src_a=1, alu_op=01, pc_src=01, pc_write=zero. Next state is FETCH; instr_done=1.
REQ-024 AEX outputs: alu_src_a=1, alu_src_b=10. Next state is AWB.
REQ-025 AWB outputs: reg_write=1, reg_dst=0, mem_to_reg=0. Next state is FETCH; instr_done=1.
REQ-026 JUMP outputs: pc_src=10, pc_write=1. Next state is FETCH; instr_done=1.
REQ-027 TRAP outputs: illegal=1. All write enables SHALL be 0. TRAP SHALL be held until rst.
REQ-028 Minimum cycles with mem_ready held 1: lw=5, sw/R/addi=4, beq/j=3. Each wait cycle SHALL add exactly one cycle.
REQ-029 instr_count SHALL increment by 1 at every edge where instr_done=1. It SHALL wrap from 0xFFFFFFFF to 0. TRAP entry SHALL NOT count.
REQ-030 reg_write and mem_write SHALL never both be 1. At most one of pc_write/reg_write/mem_write SHALL be asserted per state.

Reset
REQ-031 While rst=1, every output SHALL be forced to 0 and state SHALL load FETCH at the edge. The latched opcode and instr_count SHALL clear to 0.
REQ-032 rst asserted mid-instruction (including during a memory wait or in TRAP) SHALL abort the instruction without an instr_done pulse. The first cycle after rst falls SHALL be FETCH.

Verification
REQ-033 Reset, then R-type (opcode 000000), mem_ready=1 -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; instr_count=1.
REQ-034 lw (100011), mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4; mem_to_reg=1 in state 4; total 7 cycles.
REQ-035 beq (000100) with zero=1, then with zero=0 -> pc_write=1 with pc_src=01 in state 8 for the first; pc_write=0 for the second; both pulse instr_done.
REQ-036 opcode 111111 -> DECODE then TRAP; illegal=1 held for 10 cycles; instr_count unchanged; rst returns state to 0.
REQ-037 FETCH with mem_ready=0 for 3 cycles -> ir_write=pc_write=0 throughout; both 1 in the cycle mem_ready=1; next state 1.
REQ-038 Preload instr_count=0xFFFFFFFF (force) and execute j (000010) -> states 0,1,11,0; pc_src=10; instr_count=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute states and
// decodes datapath enables/selects from the registered state.
module mips_multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] instr_count
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REX    = 4'd6,  S_RWB   = 4'd7,
        S_BRANCH = 4'd8,  S_AEX    = 4'd9,  S_AWB    = 4'd10, S_JUMP  = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t      st;
    logic [5:0]  opc_q;
    logic [31:0] cnt;
    logic        done;

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= S_FETCH;
            opc_q <= '0;
            cnt   <= '0;
        end else begin
            if (done) cnt <= cnt + 32'd1;
            case (st)
                S_FETCH:  if (mem_ready) st <= S_DECODE;
                S_DECODE: begin
                    opc_q <= opcode;
                    case (opcode)
                        OP_R:         st <= S_REX;
                        OP_LW, OP_SW: st <= S_MEMADR;
                        OP_BEQ:       st <= S_BRANCH;
                        OP_ADDI:      st <= S_AEX;
                        OP_J:         st <= S_JUMP;
                        default:      st <= S_TRAP;
                    endcase
                end
                // memory direction comes from the opcode captured in DECODE
                S_MEMADR: st <= (opc_q == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) st <= S_MEMWB;
                S_MEMWR:  if (mem_ready) st <= S_FETCH;
                S_REX:    st <= S_RWB;
                S_AEX:    st <= S_AWB;
                S_MEMWB, S_RWB, S_BRANCH, S_AWB, S_JUMP: st <= S_FETCH;
                S_TRAP:   st <= S_TRAP;
                default:  st <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        illegal    = 1'b0;
        done       = 1'b0;
        case (st)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR, S_AEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                done       = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                done      = mem_ready;
            end
            S_REX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                done      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_write  = zero;
                done      = 1'b1;
            end
            S_AWB: begin
                reg_write = 1'b1;
                done      = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                done     = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
        // reset masks every output, including the abort of a pending instr_done
        if (rst) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            i_or_d     = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            pc_src     = 2'b00;
            illegal    = 1'b0;
        end
    end

    assign instr_done  = done & ~rst;
    assign state       = rst ? 4'd0 : st;
    assign instr_count = rst ? 32'd0 : cnt;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: per-instruction expected state sequences built from
// instruction class and planned memory waits, with randomized traffic.
module tb_mips_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write;
    logic        reg_dst, mem_to_reg, alu_src_a, instr_done, illegal;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic [3:0]  state;
    logic [31:0] instr_count;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .state(state),
        .instr_done(instr_done), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int          errs = 0;
    int          checks = 0;
    logic [31:0] mcount = '0;
    logic [4:0]  rows[$];
    logic [5:0]  ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

    wire [16:0] obs = {pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst,
                       mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, illegal, instr_done};

    // expected {pcw,irw,mrd,mwr,iod,rw,rd,m2r,asa,asb,aop,psrc,ill,done} per state
    function automatic logic [16:0] exp_outs(input logic [3:0] s, input logic mr, input logic z);
        logic pcw = 0, irw = 0, mrd = 0, mwr = 0, iod = 0, rw = 0, rd = 0, m2r = 0;
        logic asa = 0, ill = 0, dn = 0;
        logic [1:0] asb = 0, aop = 0, psrc = 0;
        case (s)
            4'd0:  begin mrd = 1; asb = 2'd1; irw = mr; pcw = mr; end
            4'd1:  asb = 2'd3;
            4'd2:  begin asa = 1; asb = 2'd2; end
            4'd3:  begin mrd = 1; iod = 1; end
            4'd4:  begin rw = 1; m2r = 1; dn = 1; end
            4'd5:  begin mwr = 1; iod = 1; dn = mr; end
            4'd6:  begin asa = 1; aop = 2'd2; end
            4'd7:  begin rw = 1; rd = 1; dn = 1; end
            4'd8:  begin asa = 1; aop = 2'd1; psrc = 2'd1; pcw = z; dn = 1; end
            4'd9:  begin asa = 1; asb = 2'd2; end
            4'd10: begin rw = 1; dn = 1; end
            4'd11: begin psrc = 2'd2; pcw = 1; dn = 1; end
            4'd12: ill = 1;
            default: ;
        endcase
        return {pcw, irw, mrd, mwr, iod, rw, rd, m2r, asa, asb, aop, psrc, ill, dn};
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        foreach (ops[i]) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // drive one cycle, check at the falling edge, advance model count on instr_done
    task automatic step(input logic [3:0] es, input logic mr, input logic z, input logic [5:0] op);
        logic [16:0] e;
        mem_ready = mr; zero = z; opcode = op;
        @(negedge clk);
        e = exp_outs(es, mr, z);
        chk($sformatf("state(exp %0d)", es), {28'd0, state}, {28'd0, es});
        chk($sformatf("outs(st %0d)", es), {15'd0, obs}, {15'd0, e});
        chk("instr_count", instr_count, mcount);
        chk("write_excl", {31'd0, ($countones({pc_write, reg_write, mem_write}) <= 1)}, 32'd1);
        if (e[0]) mcount = mcount + 32'd1;
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            mem_ready = 1'($urandom); opcode = 6'($urandom); zero = 1'($urandom);
            @(negedge clk);
            chk("rst_outs", {15'd0, obs}, 32'd0);
            chk("rst_state", {28'd0, state}, 32'd0);
            chk("rst_count", instr_count, 32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        mcount = '0;
    endtask

    // kind: 0 R, 1 lw, 2 sw, 3 beq, 4 addi, 5 j; zsel 0/1 fixed zero, 2 random
    task automatic run_instr(input int kind, input int fw, input int mw, input int zsel);
        logic z;
        rows.delete();
        repeat (fw) rows.push_back({4'd0, 1'b0});
        rows.push_back({4'd0, 1'b1});
        rows.push_back({4'd1, 1'($urandom)});
        case (kind)
            0: begin rows.push_back({4'd6, 1'($urandom)}); rows.push_back({4'd7, 1'($urandom)}); end
            1: begin
                rows.push_back({4'd2, 1'($urandom)});
                repeat (mw) rows.push_back({4'd3, 1'b0});
                rows.push_back({4'd3, 1'b1});
                rows.push_back({4'd4, 1'($urandom)});
            end
            2: begin
                rows.push_back({4'd2, 1'($urandom)});
                repeat (mw) rows.push_back({4'd5, 1'b0});
                rows.push_back({4'd5, 1'b1});
            end
            3: rows.push_back({4'd8, 1'($urandom)});
            4: begin rows.push_back({4'd9, 1'($urandom)}); rows.push_back({4'd10, 1'($urandom)}); end
            default: rows.push_back({4'd11, 1'($urandom)});
        endcase
        foreach (rows[i]) begin
            z = (zsel == 2) ? 1'($urandom) : zsel[0];
            // opcode is only meaningful in DECODE; scramble it elsewhere
            step(rows[i][4:1], rows[i][0], z, (rows[i][4:1] == 4'd1) ? ops[kind] : 6'($urandom));
        end
    endtask

    initial begin
        logic [5:0] bad;
        logic [31:0] c0;
        @(posedge clk); #1;
        do_reset(3);

        run_instr(0, 0, 0, 2);
        chk("r_type_count", instr_count, 32'd1);
        run_instr(1, 0, 2, 2);
        run_instr(3, 0, 0, 1);
        run_instr(3, 0, 0, 0);
        run_instr(2, 0, 1, 2);
        run_instr(4, 3, 0, 2);
        run_instr(5, 0, 0, 2);

        repeat (300) run_instr($urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 2), 2);

        // wrap of the retired-instruction counter
        force dut.cnt = 32'hFFFF_FFFF;
        #1 release dut.cnt;
        mcount = 32'hFFFF_FFFF;
        run_instr(5, 0, 0, 2);
        chk("count_wrap", instr_count, 32'd0);

        // reset in a MEMRD wait aborts without instr_done
        step(4'd0, 1'b1, 1'b0, 6'd0);
        step(4'd1, 1'b1, 1'b0, 6'b100011);
        step(4'd2, 1'b1, 1'b0, 6'd0);
        step(4'd3, 1'b0, 1'b0, 6'd0);
        do_reset(2);
        run_instr(1, 1, 1, 2);

        // illegal opcode traps until reset
        do bad = 6'($urandom); while (is_legal(bad));
        c0 = mcount;
        step(4'd0, 1'b1, 1'b0, 6'd0);
        step(4'd1, 1'($urandom), 1'b0, bad);
        repeat (10) step(4'd12, 1'($urandom), 1'($urandom), 6'($urandom));
        chk("trap_count", instr_count, c0);
        do_reset(1);
        run_instr(0, 0, 0, 2);
        chk("post_trap_count", instr_count, 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
